fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//   Next-PC producer and instruction-fetch sequencer for the 16-bit core. Drives the
//   next/en inputs of the PC register and consumes its PC output. Issues instruction-memory
//   requests and hands fetched instructions to IF/ID. Resolves sequential PC, branch
//   redirect, stall and HLT.
// PARAMETERS
//   WIDTH         16       address/instruction width
//   HLT_OPCODE    4'hF     instr[15:12] value that halts fetch
//   RESET_VECTOR  16'h0000 PC loaded in the first cycle after reset
// PORTS
//   clk         in   1      core clock, rising edge
//   rst         in   1      asynchronous, active-high reset
//   pc_cur      in   WIDTH  current PC from the PC register
//   imem_valid  in   1      instruction memory returns instr for imem_addr this cycle
//   instr       in   WIDTH  fetched instruction, valid with imem_valid
//   stall       in   1      hazard unit: hold PC and IF/ID
//   br_taken    in   1      EX resolved taken branch/jump (1-cycle pulse)
//   br_target   in   WIDTH  redirect address, valid with br_taken
//   pc_next     out  WIDTH  to PC register next
//   pc_en       out  1      to PC register en
//   imem_req    out  1      fetch request
//   imem_addr   out  WIDTH  fetch address (= pc_cur)
//   if_valid    out  1      instr is a valid in-path instruction for IF/ID
//   pc_plus2    out  WIDTH  pc_cur + 2, passed to IF/ID for link/branch math
//   halted      out  1      fetch stopped on HLT
// BEHAVIOUR
//   Reset (async, rst=1): state=INIT, redir_pend=0, redir_tgt=0. All outputs 0, except
//     pc_plus2, which follows pc_cur.
//   FSM states: INIT -> FETCH -> HALT. HALT is left only by reset.
//   INIT (1 cycle after rst deasserts): pc_en=1, pc_next=RESET_VECTOR, imem_req=0 -> FETCH.
//   FETCH: imem_req=1, imem_addr=pc_cur. Priority per cycle, highest first:
//     1. br_taken && imem_valid: pc_en=1, pc_next=br_target, if_valid=0 (wrong path dropped).
//        Overrides stall.
//     2. br_taken && !imem_valid: latch redir_pend=1, redir_tgt=br_target. pc_en=0.
//        A second br_taken while pending overwrites redir_tgt.
//     3. redir_pend && imem_valid: pc_en=1, pc_next=redir_tgt, if_valid=0, clear redir_pend.
//        Overrides stall.
//     4. stall: pc_en=0, if_valid=0. Memory response is discarded and re-fetched later.
//     5. imem_valid && instr[15:12]==HLT_OPCODE: if_valid=1, pc_en=0, -> HALT.
//        PC stays on the HLT instruction.
//     6. imem_valid: if_valid=1, pc_en=1, pc_next=pc_cur+2.
//     7. otherwise: wait with pc_en=0 and if_valid=0, imem_req held high.
//   HALT: halted=1, imem_req=0, pc_en=0, if_valid=0. br_taken, stall and imem_valid are ignored.
//   Arithmetic: pc_plus2 = pc_cur + 2, modulo 2^WIDTH. 16'hFFFE wraps to 16'h0000, no flag.
//   Latency: the next address reaches pc_cur on the edge after pc_en=1. With a 1-cycle
//     memory, throughput is 1 instr/cycle.
//   if_valid is combinational from state and inputs. No request is issued in the INIT cycle.
//   Reset mid-fetch: the outstanding response is forgotten and pending redirect cleared.
//     Fetch restarts at RESET_VECTOR.
// CONFIGURATION
//   FETCH_CNT_EN defined: adds output fetch_cnt [WIDTH-1:0].
//     - Reset to 0; increments on each if_valid cycle; saturates at all-ones.
//     - Also counts the HLT fetch.
//   FETCH_CNT_EN undefined: port and counter absent. All other behaviour identical.
// TESTING
//   1 Reset, 1-cycle memory, instrs 0x1000,0x2000,0x3000
//       -> pc_next 0x0000 (INIT), then 0x0002, 0x0004, 0x0006;
//       -> if_valid high 3 consecutive cycles.
//   2 pc_cur=0xFFFE, imem_valid=1 -> pc_next=0x0000, pc_en=1.
//   3 Branch with response: br_taken=1, br_target=0x0040, imem_valid=1, stall=1 same cycle
//       -> pc_next=0x0040, pc_en=1, if_valid=0.
//     Pending redirect: br_taken with imem_valid=0, memory responds 2 cycles later
//       -> if_valid=0 on that response, pc_next=0x0040, redir_pend cleared.
//   4 instr=0xF000 at pc 0x000A -> if_valid=1 once, halted=1 next cycle, pc_cur stays 0x000A.
//     Later br_taken -> no pc_en, no imem_req.
//   5 stall=1 for 3 cycles with imem_valid=1 -> pc_en=0, if_valid=0 throughout.
//     Then stall=0 -> same pc_cur fetched, if_valid=1.
//   6 rst asserted while redir_pend=1 -> outputs 0 immediately (async).
//     After release -> INIT, pc_next=0x0000; old redirect never applied.
//     With FETCH_CNT_EN, fetch_cnt=0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl - next-PC producer and instruction-fetch sequencer for the 16-bit core.
// Optional fetched-instruction counter output enabled by defining FETCH_CNT_EN.
module fetch_ctrl #(
   parameter int unsigned     WIDTH        = 16,
   parameter logic [3:0]      HLT_OPCODE   = 4'hF,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pc_cur,
   input  logic             imem_valid,
   input  logic [WIDTH-1:0] instr,
   input  logic             stall,
   input  logic             br_taken,
   input  logic [WIDTH-1:0] br_target,
   output logic [WIDTH-1:0] pc_next,
   output logic             pc_en,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   output logic             if_valid,
   output logic [WIDTH-1:0] pc_plus2,
`ifdef FETCH_CNT_EN
   output logic [WIDTH-1:0] fetch_cnt,
`endif
   output logic             halted
);

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             redir_pend_q, redir_pend_d;
   logic [WIDTH-1:0] redir_tgt_q, redir_tgt_d;

   assign pc_plus2 = pc_cur + WIDTH'(2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_INIT;
         redir_pend_q <= 1'b0;
         redir_tgt_q  <= '0;
      end else begin
         state_q      <= state_d;
         redir_pend_q <= redir_pend_d;
         redir_tgt_q  <= redir_tgt_d;
      end
   end

   // Outputs are gated by rst so they drop the moment reset is asserted.
   always_comb begin
      state_d      = state_q;
      redir_pend_d = redir_pend_q;
      redir_tgt_d  = redir_tgt_q;
      pc_next      = '0;
      pc_en        = 1'b0;
      imem_req     = 1'b0;
      imem_addr    = '0;
      if_valid     = 1'b0;
      halted       = 1'b0;
      if (!rst) begin
         case (state_q)
            ST_INIT: begin
               pc_en   = 1'b1;
               pc_next = RESET_VECTOR;
               state_d = ST_FETCH;
            end
            ST_FETCH: begin
               imem_req  = 1'b1;
               imem_addr = pc_cur;
               if (br_taken && imem_valid) begin
                  // A fresh redirect supersedes any older pending one.
                  pc_en        = 1'b1;
                  pc_next      = br_target;
                  redir_pend_d = 1'b0;
               end else if (br_taken) begin
                  redir_pend_d = 1'b1;
                  redir_tgt_d  = br_target;
               end else if (redir_pend_q && imem_valid) begin
                  pc_en        = 1'b1;
                  pc_next      = redir_tgt_q;
                  redir_pend_d = 1'b0;
               end else if (stall) begin
                  pc_en = 1'b0;
               end else if (imem_valid && instr[WIDTH-1 -: 4] == HLT_OPCODE) begin
                  if_valid = 1'b1;
                  state_d  = ST_HALT;
               end else if (imem_valid) begin
                  if_valid = 1'b1;
                  pc_en    = 1'b1;
                  pc_next  = pc_plus2;
               end
            end
            ST_HALT: begin
               halted = 1'b1;
            end
            default: begin
               state_d = ST_INIT;
            end
         endcase
      end
   end

`ifdef FETCH_CNT_EN
   logic [WIDTH-1:0] fetch_cnt_q, fetch_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      if (if_valid && fetch_cnt_q != '1)
         fetch_cnt_d = fetch_cnt_q + WIDTH'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         fetch_cnt_q <= '0;
      else
         fetch_cnt_q <= fetch_cnt_d;
   end

   assign fetch_cnt = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl with a bench-side PC register.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] pc_cur;
   logic        imem_valid = 1'b0;
   logic [15:0] instr = 16'h0000;
   logic        stall = 1'b0;
   logic        br_taken = 1'b0;
   logic [15:0] br_target = 16'h0000;
   logic [15:0] pc_next;
   logic        pc_en;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        if_valid;
   logic [15:0] pc_plus2;
   logic        halted;
`ifdef FETCH_CNT_EN
   logic [15:0] fetch_cnt;
`endif

   logic [15:0] pc_reg;
   logic        ovr_en = 1'b0;
   logic [15:0] ovr_val = 16'h0000;
   int          checks = 0;
   int          errors = 0;

   assign pc_cur = ovr_en ? ovr_val : pc_reg;

   always #5 clk = ~clk;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pc_reg <= 16'h0000;
      else if (pc_en)
         pc_reg <= pc_next;
   end

   fetch_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .pc_cur     (pc_cur),
      .imem_valid (imem_valid),
      .instr      (instr),
      .stall      (stall),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .pc_next    (pc_next),
      .pc_en      (pc_en),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .if_valid   (if_valid),
      .pc_plus2   (pc_plus2),
`ifdef FETCH_CNT_EN
      .fetch_cnt  (fetch_cnt),
`endif
      .halted     (halted)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] i, input logic s,
                        input logic b, input logic [15:0] t);
      imem_valid = v;
      instr      = i;
      stall      = s;
      br_taken   = b;
      br_target  = t;
      #1;
   endtask

   initial begin
      // Reset state
      #3;
      check("rst_pc_en", {15'd0, pc_en}, 16'h0000);
      check("rst_imem_req", {15'd0, imem_req}, 16'h0000);
      check("rst_pc_next", pc_next, 16'h0000);
      check("rst_pc_plus2", pc_plus2, 16'h0002);
      check("rst_halted", {15'd0, halted}, 16'h0000);
      next_cycle();
      rst = 1'b0;
      #1;
      check("init_pc_en", {15'd0, pc_en}, 16'h0001);
      check("init_pc_next", pc_next, 16'h0000);
      check("init_imem_req", {15'd0, imem_req}, 16'h0000);

      // Sequential fetch, 1-cycle memory
      next_cycle();
      drive(1'b1, 16'h1000, 1'b0, 1'b0, 16'h0000);
      check("seq0_addr", imem_addr, 16'h0000);
      check("seq0_req", {15'd0, imem_req}, 16'h0001);
      check("seq0_valid", {15'd0, if_valid}, 16'h0001);
      check("seq0_next", pc_next, 16'h0002);
      next_cycle();
      drive(1'b1, 16'h2000, 1'b0, 1'b0, 16'h0000);
      check("seq1_valid", {15'd0, if_valid}, 16'h0001);
      check("seq1_next", pc_next, 16'h0004);
      next_cycle();
      drive(1'b1, 16'h3000, 1'b0, 1'b0, 16'h0000);
      check("seq2_valid", {15'd0, if_valid}, 16'h0001);
      check("seq2_next", pc_next, 16'h0006);
`ifdef FETCH_CNT_EN
      next_cycle();
      check("cnt_after3", fetch_cnt, 16'h0003);
`else
      next_cycle();
`endif

      // Stall with a valid response for 3 cycles
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 16'h4000, 1'b1, 1'b0, 16'h0000);
         check("stall_pc_en", {15'd0, pc_en}, 16'h0000);
         check("stall_if_valid", {15'd0, if_valid}, 16'h0000);
         next_cycle();
      end
      drive(1'b1, 16'h4000, 1'b0, 1'b0, 16'h0000);
      check("unstall_pc", pc_cur, 16'h0006);
      check("unstall_valid", {15'd0, if_valid}, 16'h0001);
      check("unstall_next", pc_next, 16'h0008);

      // Branch with response overrides stall
      next_cycle();
      drive(1'b1, 16'h5000, 1'b1, 1'b1, 16'h0040);
      check("br_next", pc_next, 16'h0040);
      check("br_pc_en", {15'd0, pc_en}, 16'h0001);
      check("br_if_valid", {15'd0, if_valid}, 16'h0000);

      // Pending redirect resolved two cycles later
      next_cycle();
      check("br_landed", pc_cur, 16'h0040);
      drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0020);
      check("pend_pc_en", {15'd0, pc_en}, 16'h0000);
      next_cycle();
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      check("pend_wait_req", {15'd0, imem_req}, 16'h0001);
      check("pend_wait_en", {15'd0, pc_en}, 16'h0000);
      next_cycle();
      drive(1'b1, 16'h6000, 1'b0, 1'b0, 16'h0000);
      check("pend_if_valid", {15'd0, if_valid}, 16'h0000);
      check("pend_next", pc_next, 16'h0020);
      check("pend_pc_en1", {15'd0, pc_en}, 16'h0001);
      next_cycle();
      drive(1'b1, 16'h1000, 1'b0, 1'b0, 16'h0000);
      check("post_pend_valid", {15'd0, if_valid}, 16'h0001);
      check("post_pend_next", pc_next, 16'h0022);

      // Wrap at 0xFFFE
      ovr_en  = 1'b1;
      ovr_val = 16'hFFFE;
      #1;
      check("wrap_next", pc_next, 16'h0000);
      check("wrap_pc_en", {15'd0, pc_en}, 16'h0001);
      check("wrap_plus2", pc_plus2, 16'h0000);
      next_cycle();
      ovr_en = 1'b0;

      // Walk to 0x000A, then HLT
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 16'h1000, 1'b0, 1'b0, 16'h0000);
         next_cycle();
      end
      check("pre_hlt_pc", pc_cur, 16'h000A);
      drive(1'b1, 16'hF000, 1'b0, 1'b0, 16'h0000);
      check("hlt_if_valid", {15'd0, if_valid}, 16'h0001);
      check("hlt_pc_en", {15'd0, pc_en}, 16'h0000);
      next_cycle();
      drive(1'b1, 16'h1000, 1'b0, 1'b1, 16'h0040);
      check("halted", {15'd0, halted}, 16'h0001);
      check("halt_pc", pc_cur, 16'h000A);
      check("halt_br_en", {15'd0, pc_en}, 16'h0000);
      check("halt_req", {15'd0, imem_req}, 16'h0000);
      check("halt_if_valid", {15'd0, if_valid}, 16'h0000);
      next_cycle();
      check("halt_pc_hold", pc_cur, 16'h000A);

      // Reset out of HALT, create a pending redirect, reset mid-fetch
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      next_cycle();
      drive(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0040);
      check("pend2_req", {15'd0, imem_req}, 16'h0001);
      next_cycle();
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      rst = 1'b1;
      #1;
      check("async_req", {15'd0, imem_req}, 16'h0000);
      check("async_pc_en", {15'd0, pc_en}, 16'h0000);
      check("async_halted", {15'd0, halted}, 16'h0000);
      next_cycle();
      rst = 1'b0;
      #1;
      check("reinit_next", pc_next, 16'h0000);
      check("reinit_en", {15'd0, pc_en}, 16'h0001);
`ifdef FETCH_CNT_EN
      check("reinit_cnt", fetch_cnt, 16'h0000);
`endif
      next_cycle();
      drive(1'b1, 16'h1000, 1'b0, 1'b0, 16'h0000);
      check("reinit_valid", {15'd0, if_valid}, 16'h0001);
      check("no_old_redir", pc_next, 16'h0002);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
